// File: rtl/fetch_unit_if.sv
// Interface for fetch_unit: the instruction-memory req/ack port, the decode
// valid/ready port and the redirect input. The master side is the fetch stage.
interface fetch_unit_if;
  // Handshakes: imem_req/imem_addr are held until an imem_ack is sampled on a
  // rising edge with imem_req=1. if_valid/if_instr/if_pc are held until a
  // rising edge sees if_valid=1 and if_ready=1. A transfer on a redirect edge
  // is void.
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus;
  logic        halted;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus, halted,
    input  imem_ack, imem_rdata, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus, halted,
    output imem_ack, imem_rdata, redirect, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack fetch, one-deep pending buffer and
// redirect flush. Optional HALT opcode (4'b1111) support under FETCH_HALT_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic         clock,
  input  logic         resetn,
  fetch_unit_if.master fif,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] addr;
  logic        req;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] pend_instr;
  logic [15:0] pend_pc;

  logic        ack_fire;
  logic        slot_free;
  logic [15:0] pc_inc;
  logic        rdata_halt;
  logic        pend_halt;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
  assign fif.halted = (state == S_HALT);
`else
  localparam bit HALT_EN = 1'b0;
  assign fif.halted = 1'b0;
`endif

  assign ack_fire   = fif.imem_ack && req;
  assign slot_free  = !out_valid || fif.if_ready;
  assign pc_inc     = pc + PC_STEP;
  assign rdata_halt = HALT_EN && (fif.imem_rdata[15:12] == 4'hF);
  assign pend_halt  = HALT_EN && (pend_instr[15:12] == 4'hF);

  assign fif.imem_req   = req;
  assign fif.imem_addr  = addr;
  assign fif.if_valid   = out_valid;
  assign fif.if_instr   = out_instr;
  assign fif.if_pc      = out_pc;
  assign fif.if_pc_plus = out_pc + PC_STEP;
  assign dbg_state      = state;

  // addr follows pc everywhere except DROP, where the abandoned request keeps
  // its address on the bus until memory acknowledges it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      addr       <= RESET_PC;
      req        <= 1'b0;
      out_valid  <= 1'b0;
      out_instr  <= 16'h0000;
      out_pc     <= 16'h0000;
      pend_instr <= 16'h0000;
      pend_pc    <= 16'h0000;
    end else if (fif.redirect) begin
      pc        <= fif.redirect_pc;
      out_valid <= 1'b0;
      req       <= 1'b1;
      if ((state == S_REQ || state == S_DROP) && !ack_fire) begin
        state <= S_DROP;
      end else begin
        state <= S_REQ;
        addr  <= fif.redirect_pc;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req   <= 1'b1;
          addr  <= pc;
        end
        S_REQ: begin
          if (ack_fire) begin
            if (slot_free) begin
              out_valid <= 1'b1;
              out_instr <= fif.imem_rdata;
              out_pc    <= pc;
              if (rdata_halt) begin
                state <= S_HALT;
                req   <= 1'b0;
              end else begin
                pc   <= pc_inc;
                addr <= pc_inc;
              end
            end else begin
              pend_instr <= fif.imem_rdata;
              pend_pc    <= pc;
              state      <= S_HOLD;
              req        <= 1'b0;
              if (!rdata_halt) begin
                pc   <= pc_inc;
                addr <= pc_inc;
              end
            end
          end else if (fif.if_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (fif.if_ready) begin
            out_instr <= pend_instr;
            out_pc    <= pend_pc;
            if (pend_halt) begin
              state <= S_HALT;
            end else begin
              state <= S_REQ;
              req   <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (ack_fire) begin
            state <= S_REQ;
            addr  <= pc;
          end
        end
        S_HALT: begin
          if (fif.if_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory latency,
// backpressure and redirects checked against a stream-level reference model.
module tb_fetch_unit;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  fetch_unit_if fif ();
  fetch_unit_if wif ();
  logic [2:0] dbg_state;
  logic [2:0] wdbg_state;

  fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) u_dut (
    .clock     (clock),
    .resetn    (resetn),
    .fif       (fif),
    .dbg_state (dbg_state)
  );

  fetch_unit #(.RESET_PC(16'hFFFE), .PC_STEP(16'd2)) u_wrap (
    .clock     (clock),
    .resetn    (resetn),
    .fif       (wif),
    .dbg_state (wdbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Program image: a fixed function of the address; never opcode 4'hF.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [3:0] op;
    op = a[4:1];
    if (op == 4'hF) op = 4'hE;
    return {op, a[11:0] ^ 12'h5A5};
  endfunction

  task automatic drive_idle();
    fif.imem_ack    = 1'b0;
    fif.imem_rdata  = 16'h0000;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 16'h0000;
    fif.if_ready    = 1'b0;
  endtask

  task automatic mem_ack(input logic [15:0] d);
    fif.imem_ack   = 1'b1;
    fif.imem_rdata = d;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    drive_idle();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  logic [15:0] exp_pc, fetch_pc, prev_addr, rp;
  bit          drop, prev_req, prev_ack, rdy, rdr, ack;
  int          delivered;

  initial begin
    drive_idle();
    wif.imem_ack    = 1'b1;
    wif.imem_rdata  = 16'h1234;
    wif.redirect    = 1'b0;
    wif.redirect_pc = 16'h0000;
    wif.if_ready    = 1'b1;

    // Reset values
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_req",    16'(fif.imem_req), 16'd0);
    check_eq("rst_valid",  16'(fif.if_valid), 16'd0);
    check_eq("rst_addr",   fif.imem_addr, 16'h0000);
    check_eq("rst_instr",  fif.if_instr, 16'h0000);
    check_eq("rst_pc",     fif.if_pc, 16'h0000);
    check_eq("rst_halted", 16'(fif.halted), 16'd0);
    check_eq("wrap_rst_req", 16'(wif.imem_req), 16'd0);

    resetn = 1'b1;
    @(negedge clock);
    check_eq("first_req",  16'(fif.imem_req), 16'd1);
    check_eq("first_addr", fif.imem_addr, 16'h0000);
    check_eq("wrap_req",   16'(wif.imem_req), 16'd1);
    check_eq("wrap_addr0", wif.imem_addr, 16'hFFFE);

    // Zero-wait stream
    fif.if_ready = 1'b1;
    mem_ack(16'h0A10);
    @(negedge clock);
    check_eq("s0_instr", fif.if_instr, 16'h0A10);
    check_eq("s0_pc",    fif.if_pc, 16'h0000);
    check_eq("s0_valid", 16'(fif.if_valid), 16'd1);
    check_eq("s0_addr",  fif.imem_addr, 16'h0002);
    check_eq("wrap_if_pc",   wif.if_pc, 16'hFFFE);
    check_eq("wrap_pc_plus", wif.if_pc_plus, 16'h0000);
    check_eq("wrap_addr1",   wif.imem_addr, 16'h0000);
    mem_ack(16'h1B20);
    @(negedge clock);
    check_eq("s1_instr", fif.if_instr, 16'h1B20);
    check_eq("s1_pc",    fif.if_pc, 16'h0002);
    mem_ack(16'h2C30);
    @(negedge clock);
    check_eq("s2_instr", fif.if_instr, 16'h2C30);
    check_eq("s2_pc",    fif.if_pc, 16'h0004);
    check_eq("s2_addr",  fif.imem_addr, 16'h0006);

    // Reset mid-fetch takes effect without a clock edge
    fif.imem_ack = 1'b0;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_req",   16'(fif.imem_req), 16'd0);
    check_eq("mid_rst_valid", 16'(fif.if_valid), 16'd0);
    check_eq("mid_rst_addr",  fif.imem_addr, 16'h0000);
    drive_idle();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Backpressure
    fif.if_ready = 1'b1;
    mem_ack(16'h0A10);
    @(negedge clock);
    check_eq("bp_first", fif.if_instr, 16'h0A10);
    fif.if_ready = 1'b0;
    mem_ack(16'h1B20);
    @(negedge clock);
    check_eq("bp_hold_req",   16'(fif.imem_req), 16'd0);
    check_eq("bp_hold_addr",  fif.imem_addr, 16'h0004);
    check_eq("bp_hold_instr", fif.if_instr, 16'h0A10);
    check_eq("bp_hold_valid", 16'(fif.if_valid), 16'd1);
    fif.imem_ack = 1'b0;
    fif.if_ready = 1'b1;
    @(negedge clock);
    check_eq("bp_rel_instr", fif.if_instr, 16'h1B20);
    check_eq("bp_rel_pc",    fif.if_pc, 16'h0002);
    check_eq("bp_rel_req",   16'(fif.imem_req), 16'd1);
    check_eq("bp_rel_addr",  fif.imem_addr, 16'h0004);
    @(negedge clock);
    check_eq("bp_drain_valid", 16'(fif.if_valid), 16'd0);

    // Redirect while a request to 0002 is outstanding
    do_reset();
    fif.if_ready = 1'b1;
    mem_ack(16'h0A10);
    @(negedge clock);
    fif.imem_ack = 1'b0;
    fif.if_ready = 1'b0;
    @(negedge clock);
    fif.redirect    = 1'b1;
    fif.redirect_pc = 16'h0040;
    @(negedge clock);
    fif.redirect = 1'b0;
    check_eq("rd_drop_addr",  fif.imem_addr, 16'h0002);
    check_eq("rd_drop_req",   16'(fif.imem_req), 16'd1);
    check_eq("rd_drop_valid", 16'(fif.if_valid), 16'd0);
    @(negedge clock);
    check_eq("rd_drop_addr2", fif.imem_addr, 16'h0002);
    mem_ack(16'hDEAD);
    @(negedge clock);
    fif.imem_ack = 1'b0;
    check_eq("rd_after_valid", 16'(fif.if_valid), 16'd0);
    check_eq("rd_after_req",   16'(fif.imem_req), 16'd1);
    check_eq("rd_after_addr",  fif.imem_addr, 16'h0040);
    fif.if_ready = 1'b1;
    mem_ack(16'h3C40);
    @(negedge clock);
    fif.imem_ack = 1'b0;
    check_eq("rd_new_instr", fif.if_instr, 16'h3C40);
    check_eq("rd_new_pc",    fif.if_pc, 16'h0040);

    // Opcode F at 0006
    do_reset();
    fif.if_ready = 1'b1;
    mem_ack(16'h0A10);
    @(negedge clock);
    mem_ack(16'h1B20);
    @(negedge clock);
    mem_ack(16'h2C30);
    @(negedge clock);
    mem_ack(16'hF000);
    @(negedge clock);
    check_eq("f_instr", fif.if_instr, 16'hF000);
    check_eq("f_pc",    fif.if_pc, 16'h0006);
`ifdef FETCH_HALT_EN
    check_eq("halt_flag", 16'(fif.halted), 16'd1);
    check_eq("halt_req",  16'(fif.imem_req), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("halt_once_valid", 16'(fif.if_valid), 16'd0);
      check_eq("halt_stay_req",   16'(fif.imem_req), 16'd0);
      check_eq("halt_stay_flag",  16'(fif.halted), 16'd1);
    end
    fif.imem_ack    = 1'b0;
    fif.redirect    = 1'b1;
    fif.redirect_pc = 16'h0010;
    @(negedge clock);
    fif.redirect = 1'b0;
    check_eq("halt_exit_flag", 16'(fif.halted), 16'd0);
    check_eq("halt_exit_req",  16'(fif.imem_req), 16'd1);
    check_eq("halt_exit_addr", fif.imem_addr, 16'h0010);
`else
    check_eq("f_plain_halted", 16'(fif.halted), 16'd0);
    check_eq("f_plain_req",    16'(fif.imem_req), 16'd1);
    check_eq("f_plain_addr",   fif.imem_addr, 16'h0008);
    fif.imem_ack = 1'b0;
`endif

    // Randomized: delivered stream must be the program from the latest
    // redirect target onward; each useful ack must be at the next fetch address.
    do_reset();
    exp_pc    = 16'h0000;
    fetch_pc  = 16'h0000;
    drop      = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 16'h0000;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_req && !prev_ack) begin
        check_eq("rnd_req_stable",  16'(fif.imem_req), 16'd1);
        check_eq("rnd_addr_stable", fif.imem_addr, prev_addr);
      end
      if (fif.if_valid) check_eq("rnd_pc_plus", fif.if_pc_plus, fif.if_pc + 16'd2);

      rdy = ($urandom_range(0, 3) != 0);
      rdr = ($urandom_range(0, 15) == 0);
      rp  = 16'($urandom);
      rp[0] = 1'b0;
      if ($urandom_range(0, 3) == 0) rp = 16'hFFFC;
      ack = fif.imem_req && ($urandom_range(0, 1) == 1);
      fif.if_ready    = rdy;
      fif.redirect    = rdr;
      fif.redirect_pc = rp;
      fif.imem_ack    = ack;
      fif.imem_rdata  = ack ? mem_word(fif.imem_addr) : 16'($urandom);

      if (fif.if_valid && rdy && !rdr) begin
        check_eq("rnd_if_pc",    fif.if_pc, exp_pc);
        check_eq("rnd_if_instr", fif.if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 16'd2;
        delivered++;
      end
      if (rdr) begin
        exp_pc   = rp;
        fetch_pc = rp;
        drop     = fif.imem_req && !ack;
      end else if (ack) begin
        if (drop) begin
          drop = 1'b0;
        end else begin
          check_eq("rnd_fetch_addr", fif.imem_addr, fetch_pc);
          fetch_pc = fetch_pc + 16'd2;
        end
      end
      prev_req  = fif.imem_req;
      prev_ack  = ack;
      prev_addr = fif.imem_addr;
      @(negedge clock);
    end
    drive_idle();
    check_eq("rnd_progress", 16'(delivered > 300), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
